// File: rtl/seq_multiplier_hs_if.sv
// Handshake bundle for seq_multiplier_hs: operand/mode request channel and result channel.
// master = requester (drives operands, consumes result); slave = the multiplier.
interface seq_multiplier_hs_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic           is_signed;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;

  modport master (
    output in_valid, is_signed, multiplicand, multiplier, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, is_signed, multiplicand, multiplier, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/seq_multiplier_hs.sv
// Sequential shift-add multiplier, one multiplier bit per clock, signed/unsigned at runtime.
// Optional macro SEQ_MULT_EARLY_TERM_EN: leave CALC once the remaining multiplier bits are all zero.
module seq_multiplier_hs #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                reset,
  seq_multiplier_hs_if.slave  bus,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0]   ONE_W  = W'(1);
  localparam logic [2*W-1:0] ONE_2W = (2*W)'(1);

  // Handshake: a transfer happens on a rising clk edge where valid && ready are both high.
  // in_ready is high only in IDLE; out_valid is high only in VALID, where result is held
  // until out_ready is seen. Neither ready depends combinationally on the peer's valid.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIX   = 2'd2,
    S_VALID = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic           sign_neg_q;
  logic [W-1:0]   mcand_q;
  logic [W-1:0]   acc_q;
  logic [W-1:0]   q_q;
  logic [CW-1:0]  count_q;
  logic [2*W-1:0] result_q;
`ifdef SEQ_MULT_EARLY_TERM_EN
  logic [W-1:0]   mq_q;
`endif

  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W:0]     sum;
  logic           calc_done;
  logic [2*W-1:0] prod_al;
  logic [2*W-1:0] prod_fix;

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (calc_done) state_d = S_FIX;
      end
      S_FIX: begin
        busy    = 1'b1;
        state_d = S_VALID;
      end
      S_VALID: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // The most negative value negates to itself, which is exactly its unsigned magnitude.
  always_comb begin
    a_mag = (bus.is_signed && bus.multiplicand[W-1]) ? (~bus.multiplicand + ONE_W)
                                                      : bus.multiplicand;
    b_mag = (bus.is_signed && bus.multiplier[W-1])   ? (~bus.multiplier + ONE_W)
                                                      : bus.multiplier;
    sum       = {1'b0, acc_q} + (q_q[0] ? {1'b0, mcand_q} : '0);
    calc_done = (count_q == CW'(1));
`ifdef SEQ_MULT_EARLY_TERM_EN
    calc_done = calc_done || ((mq_q >> 1) == '0);
    // Unconsumed positions of q are zero; shifting them out realigns the product.
    prod_al   = {acc_q, q_q} >> count_q;
`else
    prod_al   = {acc_q, q_q};
`endif
    prod_fix  = sign_neg_q ? (~prod_al + ONE_2W) : prod_al;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_neg_q <= 1'b0;
      mcand_q    <= '0;
      acc_q      <= '0;
      q_q        <= '0;
      count_q    <= '0;
      result_q   <= '0;
`ifdef SEQ_MULT_EARLY_TERM_EN
      mq_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            sign_neg_q <= bus.is_signed & (bus.multiplicand[W-1] ^ bus.multiplier[W-1]);
            mcand_q    <= a_mag;
            q_q        <= b_mag;
            acc_q      <= '0;
            count_q    <= CW'(W);
`ifdef SEQ_MULT_EARLY_TERM_EN
            mq_q       <= b_mag;
`endif
          end
        end
        S_CALC: begin
          // Carry out of the add lands in the top of acc during the same shift.
          acc_q   <= sum[W:1];
          q_q     <= {sum[0], q_q[W-1:1]};
          count_q <= count_q - CW'(1);
`ifdef SEQ_MULT_EARLY_TERM_EN
          mq_q    <= mq_q >> 1;
`endif
        end
        S_FIX: result_q <= prod_fix;
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_seq_multiplier_hs.sv
// Testbench for seq_multiplier_hs: directed and random operations against an arithmetic reference.
module tb_seq_multiplier_hs;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [1:0] state_dbg;

  int vectors     = 0;
  int miscompares = 0;

  seq_multiplier_hs_if #(.W(W)) mif ();

  seq_multiplier_hs #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (mif),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
    longint pa, pb, p;
    pa = s ? longint'($signed(a)) : longint'(a);
    pb = s ? longint'($signed(b)) : longint'(b);
    p  = pa * pb;
    return p[2*W-1:0];
  endfunction

  function automatic int ref_lat(input logic [W-1:0] b, input logic s);
`ifdef SEQ_MULT_EARLY_TERM_EN
    int mag, m;
    mag = (s && b[W-1]) ? (1 << W) - int'(b) : int'(b);
    m = 0;
    for (int i = 0; i <= W; i++) if (mag >= (1 << i)) m = i + 1;
    return ((m < 1) ? 1 : m) + 1;
`else
    if (s) return W + 1;
    return b * 0 + W + 1;
`endif
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int hold, input string tag);
    logic [2*W-1:0] exp_r;
    int exp_l, lat, cyc, bad_calc, bad_hold;
    logic seen;
    exp_r = ref_prod(a, b, s);
    exp_l = ref_lat(b, s);
    cyc = 0;
    while (mif.in_ready !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".in_ready_idle"}, 16'(mif.in_ready), 16'd1);
    mif.in_valid     = 1'b1;
    mif.multiplicand = a;
    mif.multiplier   = b;
    mif.is_signed    = s;
    mif.out_ready    = (hold == 0);
    @(posedge clk); #1;
    // operands change after the accept edge; the block must ignore them
    mif.in_valid     = 1'b0;
    mif.multiplicand = W'($urandom);
    mif.multiplier   = W'($urandom);
    mif.is_signed    = ~s;
    lat = 0; seen = 1'b0; bad_calc = 0;
    if (mif.in_ready !== 1'b0 || busy !== 1'b1) bad_calc++;
    while (!seen && lat < 4 * W) begin
      @(posedge clk); #1;
      lat++;
      if (mif.out_valid === 1'b1) seen = 1'b1;
      else if (mif.in_ready !== 1'b0 || busy !== 1'b1) bad_calc++;
    end
    check({tag, ".out_valid_seen"}, 16'(seen), 16'd1);
    check({tag, ".latency"}, 16'(lat), 16'(exp_l));
    check({tag, ".result"}, mif.result, exp_r);
    check({tag, ".calc_flags_bad"}, 16'(bad_calc), 16'd0);
    check({tag, ".busy_in_valid"}, 16'(busy), 16'd0);
    bad_hold = 0;
    for (int i = 0; i < hold; i++) begin
      mif.in_valid = 1'b1;
      @(posedge clk); #1;
      if (mif.out_valid !== 1'b1 || mif.result !== exp_r || mif.in_ready !== 1'b0) bad_hold++;
    end
    check({tag, ".hold_bad"}, 16'(bad_hold), 16'd0);
    mif.in_valid  = 1'b0;
    mif.out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, ".out_valid_drop"}, 16'(mif.out_valid), 16'd0);
    check({tag, ".in_ready_back"}, 16'(mif.in_ready), 16'd1);
    check({tag, ".result_held"}, mif.result, exp_r);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    reset            = 1'b1;
    mif.in_valid     = 1'b0;
    mif.is_signed    = 1'b0;
    mif.multiplicand = '0;
    mif.multiplier   = '0;
    mif.out_ready    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.result", mif.result, '0);
    check("rst.out_valid", 16'(mif.out_valid), 16'd0);
    check("rst.in_ready", 16'(mif.in_ready), 16'd1);
    check("rst.busy", 16'(busy), 16'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(8'hFF, 8'hFF, 1'b0, 0, "uns_ff_ff");
    run_op(8'hFD, 8'h05, 1'b1, 0, "sgn_m3_5");
    run_op(8'h05, 8'hFD, 1'b1, 0, "sgn_5_m3");
    run_op(8'h80, 8'h80, 1'b1, 0, "sgn_80_80");
    run_op(8'h80, 8'h80, 1'b0, 0, "uns_80_80");
    run_op(8'h80, 8'h01, 1'b1, 0, "sgn_80_01");
    run_op(8'h00, 8'hFF, 1'b1, 0, "sgn_zero_neg");
    run_op(8'h11, 8'h05, 1'b0, 0, "uns_11_05");
    run_op(8'h37, 8'h00, 1'b0, 0, "uns_b_zero");
    run_op(8'h23, 8'h80, 1'b0, 0, "uns_b_80");
    run_op(8'h9C, 8'h6B, 1'b1, 5, "backpressure");

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255) >> $urandom_range(0, 7));
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, $urandom_range(0, 2), "random");
    end

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    mif.in_valid     = 1'b1;
    mif.multiplicand = 8'h55;
    mif.multiplier   = 8'hFF;
    mif.is_signed    = 1'b0;
    mif.out_ready    = 1'b1;
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("abort.busy_before", 16'(busy), 16'd1);
    reset = 1'b1;
    #1;
    check("abort.out_valid", 16'(mif.out_valid), 16'd0);
    check("abort.busy", 16'(busy), 16'd0);
    check("abort.in_ready", 16'(mif.in_ready), 16'd1);
    check("abort.result", mif.result, '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op(8'd7, 8'd6, 1'b0, 0, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
